// File: rtl/dbf_apod_ch.sv
// Per-channel dynamic apodization: each accepted fine-delay sample is multiplied by a
// depth-indexed window coefficient from a locally loaded LUT, rounded half up and scaled.
module dbf_apod_ch #(
    parameter int FD_OUT_WD = 16,
    parameter int APO_WD    = 16,
    parameter int APO_FRAC  = 15,
    parameter int ADDR_WD   = 10,
    parameter int OUT_WD    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [FD_OUT_WD-1:0] fine_din,
    input  logic                        fine_din_valid,
    input  logic        [ADDR_WD-1:0]   lut_addr,
    input  logic                        lut_we,
    input  logic signed [APO_WD-1:0]    lut_din,
    output logic signed [OUT_WD-1:0]    apo_dout,
    output logic                        apo_dout_valid,
    output logic                        busy
);

    localparam int PROD_WD = FD_OUT_WD + APO_WD;
    localparam logic [ADDR_WD-1:0] IDX_MAX = '1;
    localparam logic signed [PROD_WD:0] RND_BIAS = (PROD_WD+1)'(1) <<< (APO_FRAC - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t                      state_q;
    logic [1:0]                  drain_cnt_q;
    logic [ADDR_WD-1:0]          index_q;
    logic                        busy_q;

    logic signed [APO_WD-1:0]    coef_ram [2**ADDR_WD];

    logic                        s1_vld_q, s2_vld_q, s3_vld_q, out_vld_q;
    logic signed [FD_OUT_WD-1:0] s1_sample_q, s2_sample_q;
    logic        [ADDR_WD-1:0]   s1_addr_q;
    logic signed [APO_WD-1:0]    s2_coef_q;
    logic signed [PROD_WD-1:0]   s3_prod_q;
    logic signed [OUT_WD-1:0]    dout_q;

    logic                        accept_d;
    logic                        lut_wr_d;
    logic signed [PROD_WD-1:0]   prod_d;
    logic signed [PROD_WD:0]     rnd_sum_d;
    logic signed [PROD_WD:0]     rnd_shift_d;

    assign accept_d = (state_q == ACTIVE) && fine_din_valid;
    assign lut_wr_d = lut_we && (state_q == IDLE);

    // Line-control FSM: the sample index restarts at 0 whenever a line (re)starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            index_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACTIVE;
                        index_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (fine_din_valid && (index_q != IDX_MAX)) begin
                        index_q <= index_q + ADDR_WD'(1);
                    end
                    if (!start) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == 2'd2) begin
                        if (start) begin
                            state_q <= ACTIVE;
                            index_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the coefficient RAM and pipeline data registers are deliberately not reset;
    // only the qualifiers are, so the LUT survives rst and maps onto block RAM.
    always_ff @(posedge clk) begin
        if (lut_wr_d) begin
            coef_ram[lut_addr] <= lut_din;
        end
        s2_coef_q <= coef_ram[s1_addr_q];
    end

    always_ff @(posedge clk) begin
        s1_sample_q <= fine_din;
        s1_addr_q   <= index_q;
        s2_sample_q <= s1_sample_q;
        s3_prod_q   <= prod_d;
    end

    assign prod_d      = PROD_WD'(s2_sample_q) * PROD_WD'(s2_coef_q);
    assign rnd_sum_d   = (PROD_WD+1)'(s3_prod_q) + RND_BIAS;
    assign rnd_shift_d = rnd_sum_d >>> APO_FRAC;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            s1_vld_q  <= accept_d;
            s2_vld_q  <= s1_vld_q;
            s3_vld_q  <= s2_vld_q;
            out_vld_q <= s3_vld_q;
            dout_q    <= s3_vld_q ? OUT_WD'(rnd_shift_d) : '0;
        end
    end

    assign apo_dout       = dout_q;
    assign apo_dout_valid = out_vld_q;
    assign busy           = busy_q;

endmodule
